// File: rtl/tmr_fault_monitor_if.sv
// tmr_fault_monitor_if
//   Event stream from the TMR fault monitor to its consumer.
//   master (monitor): drives evt_valid, evt_data, evt_overflow; samples evt_ready
//   slave (consumer): samples evt_valid, evt_data, evt_overflow; drives evt_ready
//   evt_data layout: {mask[2:0], multi_fault, voted_q[WIDTH-1:0]}
interface tmr_fault_monitor_if #(
  parameter int WIDTH = 4
);
  logic             evt_valid;
  logic             evt_ready;
  logic [WIDTH+3:0] evt_data;
  logic             evt_overflow;

  modport master (output evt_valid, output evt_data, output evt_overflow, input evt_ready);
  modport slave  (input evt_valid, input evt_data, input evt_overflow, output evt_ready);
endinterface

// File: rtl/tmr_fault_monitor.sv
// tmr_fault_monitor
//   Passive observer of a triple-redundant counter stage. On each sampled
//   cycle it compares the three replicas with the voted value, keeps
//   saturating per-replica mismatch counts, classifies each replica
//   (OK / SUSPECT / STUCK) and logs mismatch events into a small FIFO.
//
//   Build option: define TMR_MON_EVENT_LOG_EN to build the event FIFO.
//   Without it the event outputs are tied to 0 and evt_ready is ignored.
//
//   Ports
//     clk, rst            clock, synchronous active-high reset
//     sample              qualifies q_1..q_3 / voted_q this cycle
//     q_1, q_2, q_3       replica outputs
//     voted_q             voter output
//     clr_stats           clears counters, replica states, stuck, overflow
//     err_cnt_1..3        saturating mismatch counts per replica
//     stuck               bit i-1 set while replica i is STUCK
//     multi_fault         all three replicas differed at the previous sample
//     evt                 event stream (master modport)
//
//   Replica state | meaning
//   --------------+-------------------------------------------------
//   ST_OK         | no mismatch on the most recent sample
//   ST_SUSPECT    | 1..PERSIST-1 consecutive mismatching samples
//   ST_STUCK      | PERSIST consecutive mismatches; held until clear
module tmr_fault_monitor #(
  parameter int WIDTH      = 4,
  parameter int CNT_WIDTH  = 8,
  parameter int PERSIST    = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sample,
  input  logic [WIDTH-1:0]     q_1,
  input  logic [WIDTH-1:0]     q_2,
  input  logic [WIDTH-1:0]     q_3,
  input  logic [WIDTH-1:0]     voted_q,
  input  logic                 clr_stats,
  output logic [CNT_WIDTH-1:0] err_cnt_1,
  output logic [CNT_WIDTH-1:0] err_cnt_2,
  output logic [CNT_WIDTH-1:0] err_cnt_3,
  output logic [2:0]           stuck,
  output logic                 multi_fault,
  tmr_fault_monitor_if.master  evt
);

  typedef enum logic [1:0] {
    ST_OK      = 2'd0,
    ST_SUSPECT = 2'd1,
    ST_STUCK   = 2'd2
  } rep_state_t;

  localparam logic [3:0]           PERSIST_4 = 4'(PERSIST);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;

  logic [2:0] mis;
  logic       mf_now;
  logic       take;

  assign mis[0] = (q_1 != voted_q);
  assign mis[1] = (q_2 != voted_q);
  assign mis[2] = (q_3 != voted_q);
  assign mf_now = (q_1 != q_2) && (q_1 != q_3) && (q_2 != q_3);
  // A sample coinciding with clr_stats is discarded entirely.
  assign take   = sample && !clr_stats;

  rep_state_t           state [3];
  // Down-counter of mismatches still needed before STUCK; STUCK on terminal count.
  logic [3:0]           left  [3];
  logic [CNT_WIDTH-1:0] cnt   [3];

  always_ff @(posedge clk) begin
    if (rst || clr_stats) begin
      for (int i = 0; i < 3; i++) begin
        state[i] <= ST_OK;
        left[i]  <= '0;
        cnt[i]   <= '0;
        stuck[i] <= 1'b0;
      end
    end else if (sample) begin
      for (int i = 0; i < 3; i++) begin
        if (mis[i] && (cnt[i] != CNT_MAX)) begin
          cnt[i] <= cnt[i] + 1'b1;
        end
        case (state[i])
          ST_OK: begin
            if (mis[i]) begin
              if (PERSIST_4 == 4'd1) begin
                state[i] <= ST_STUCK;
                stuck[i] <= 1'b1;
                left[i]  <= '0;
              end else begin
                state[i] <= ST_SUSPECT;
                left[i]  <= PERSIST_4 - 4'd1;
              end
            end
          end
          ST_SUSPECT: begin
            if (mis[i]) begin
              left[i] <= left[i] - 4'd1;
              if (left[i] == 4'd1) begin
                state[i] <= ST_STUCK;
                stuck[i] <= 1'b1;
              end
            end else begin
              state[i] <= ST_OK;
              left[i]  <= '0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) multi_fault <= 1'b0;
    else     multi_fault <= take && mf_now;
  end

  assign err_cnt_1 = cnt[0];
  assign err_cnt_2 = cnt[1];
  assign err_cnt_3 = cnt[2];

`ifdef TMR_MON_EVENT_LOG_EN
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [WIDTH+3:0] mem [FIFO_DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic             full, push_req, pop, push;

  // Extra pointer bit separates full from empty when the indexes match.
  assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push_req   = take && (|mis);
  assign pop        = evt.evt_valid && evt.evt_ready;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push       = push_req && (!full || pop);
  assign wr_ptr_nxt = wr_ptr + {{AW{1'b0}}, push};
  assign rd_ptr_nxt = rd_ptr + {{AW{1'b0}}, pop};

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      evt.evt_valid    <= 1'b0;
      evt.evt_overflow <= 1'b0;
    end else begin
      wr_ptr        <= wr_ptr_nxt;
      rd_ptr        <= rd_ptr_nxt;
      evt.evt_valid <= (wr_ptr_nxt != rd_ptr_nxt);
      if (clr_stats) begin
        evt.evt_overflow <= 1'b0;
      end else if (push_req && full && !pop) begin
        evt.evt_overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= {mis[2], mis[1], mis[0], mf_now, voted_q};
    end
  end

  // Storage is not reset; gate the head so evt_data reads 0 while empty.
  assign evt.evt_data = evt.evt_valid ? mem[rd_ptr[AW-1:0]] : '0;
`else
  logic unused_evt_ready;
  assign unused_evt_ready = evt.evt_ready;
  assign evt.evt_valid    = 1'b0;
  assign evt.evt_data     = '0;
  assign evt.evt_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_tmr_fault_monitor.sv
module tb_tmr_fault_monitor;
  localparam int WIDTH = 4;
  localparam int CNT_WIDTH = 8;

  logic       clk = 1'b0;
  logic       rst, sample, clr_stats;
  logic [3:0] q_1, q_2, q_3, voted_q;
  logic [7:0] err_cnt_1, err_cnt_2, err_cnt_3;
  logic [2:0] stuck;
  logic       multi_fault;
  int         checks = 0;
  int         errors = 0;

  tmr_fault_monitor_if #(.WIDTH(WIDTH)) evt_if ();

  tmr_fault_monitor #(
    .WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH), .PERSIST(3), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .sample(sample),
    .q_1(q_1), .q_2(q_2), .q_3(q_3), .voted_q(voted_q),
    .clr_stats(clr_stats),
    .err_cnt_1(err_cnt_1), .err_cnt_2(err_cnt_2), .err_cnt_3(err_cnt_3),
    .stuck(stuck), .multi_fault(multi_fault),
    .evt(evt_if.master)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] c, input logic [3:0] v);
    sample = s; q_1 = a; q_2 = b; q_3 = c; voted_q = v;
  endtask

  task automatic do_clear();
    clr_stats = 1'b1; sample = 1'b0;
    tick();
    clr_stats = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; clr_stats = 1'b0; evt_if.evt_ready = 1'b0;
    drive(1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
    tick(); tick();
    rst = 1'b0;
    checks++; if (err_cnt_1 !== 8'd0) begin errors++; $display("FAIL reset_cnt1 got %0d exp 0", err_cnt_1); end
    checks++; if (err_cnt_2 !== 8'd0) begin errors++; $display("FAIL reset_cnt2 got %0d exp 0", err_cnt_2); end
    checks++; if (err_cnt_3 !== 8'd0) begin errors++; $display("FAIL reset_cnt3 got %0d exp 0", err_cnt_3); end
    checks++; if (stuck !== 3'b000) begin errors++; $display("FAIL reset_stuck got %b exp 000", stuck); end
    checks++; if (multi_fault !== 1'b0) begin errors++; $display("FAIL reset_mf got %b exp 0", multi_fault); end
    checks++; if (evt_if.evt_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", evt_if.evt_valid); end
    checks++; if (evt_if.evt_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h exp 00", evt_if.evt_data); end
    checks++; if (evt_if.evt_overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", evt_if.evt_overflow); end
  endtask

  task automatic test_clean();
    logic seen = 1'b0;
    drive(1'b1, 4'h5, 4'h5, 4'h5, 4'h5);
    repeat (10) begin
      tick();
      if (evt_if.evt_valid !== 1'b0) seen = 1'b1;
    end
    sample = 1'b0;
    checks++; if ({err_cnt_1, err_cnt_2, err_cnt_3} !== 24'd0) begin errors++; $display("FAIL clean_cnts got %0d/%0d/%0d exp 0/0/0", err_cnt_1, err_cnt_2, err_cnt_3); end
    checks++; if (stuck !== 3'b000) begin errors++; $display("FAIL clean_stuck got %b exp 000", stuck); end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL clean_evt_valid got %b exp 0", seen); end
  endtask

  task automatic test_persist();
    evt_if.evt_ready = 1'b0;
    drive(1'b1, 4'h5, 4'h7, 4'h5, 4'h5);
    tick();
    checks++; if (err_cnt_2 !== 8'd1) begin errors++; $display("FAIL persist_cnt2_1 got %0d exp 1", err_cnt_2); end
    checks++; if (stuck !== 3'b000) begin errors++; $display("FAIL persist_stuck_1 got %b exp 000", stuck); end
    tick();
    checks++; if (stuck !== 3'b000) begin errors++; $display("FAIL persist_stuck_2 got %b exp 000", stuck); end
    tick();
    sample = 1'b0;
    checks++; if (err_cnt_2 !== 8'd3) begin errors++; $display("FAIL persist_cnt2_3 got %0d exp 3", err_cnt_2); end
    checks++; if (stuck !== 3'b010) begin errors++; $display("FAIL persist_stuck_3 got %b exp 010", stuck); end
    checks++; if (err_cnt_1 !== 8'd0 || err_cnt_3 !== 8'd0) begin errors++; $display("FAIL persist_others got %0d/%0d exp 0/0", err_cnt_1, err_cnt_3); end
`ifdef TMR_MON_EVENT_LOG_EN
    evt_if.evt_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      checks++; if (evt_if.evt_valid !== 1'b1 || evt_if.evt_data !== 8'h45) begin errors++; $display("FAIL persist_evt%0d got v=%b d=%h exp v=1 d=45", k, evt_if.evt_valid, evt_if.evt_data); end
      tick();
    end
    evt_if.evt_ready = 1'b0;
    checks++; if (evt_if.evt_valid !== 1'b0) begin errors++; $display("FAIL persist_drained got %b exp 0", evt_if.evt_valid); end
`else
    checks++; if (evt_if.evt_valid !== 1'b0) begin errors++; $display("FAIL persist_no_log got %b exp 0", evt_if.evt_valid); end
`endif
    tick();
    checks++; if (stuck !== 3'b010) begin errors++; $display("FAIL persist_hold got %b exp 010", stuck); end
    do_clear();
    checks++; if (stuck !== 3'b000 || err_cnt_2 !== 8'd0) begin errors++; $display("FAIL persist_clr got stuck=%b cnt2=%0d exp 000/0", stuck, err_cnt_2); end
  endtask

  task automatic test_run_break();
    logic [4:0] pat;
    pat = 5'b11011;
    evt_if.evt_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, pat[k] ? 4'h3 : 4'h5, 4'h5, 4'h5, 4'h5);
      tick();
    end
    sample = 1'b0;
    checks++; if (err_cnt_1 !== 8'd4) begin errors++; $display("FAIL break_cnt1 got %0d exp 4", err_cnt_1); end
    checks++; if (stuck !== 3'b000) begin errors++; $display("FAIL break_stuck got %b exp 000", stuck); end
    do_clear();
    tick(); tick();
    // mismatch, gap, mismatch, gap, gap, mismatch
    drive(1'b1, 4'h3, 4'h5, 4'h5, 4'h5); tick();
    sample = 1'b0; tick();
    sample = 1'b1; tick();
    sample = 1'b0; tick(); tick();
    checks++; if (stuck !== 3'b000) begin errors++; $display("FAIL gap_stuck_2 got %b exp 000", stuck); end
    sample = 1'b1; tick();
    sample = 1'b0;
    checks++; if (stuck !== 3'b001) begin errors++; $display("FAIL gap_stuck_3 got %b exp 001", stuck); end
    checks++; if (err_cnt_1 !== 8'd3) begin errors++; $display("FAIL gap_cnt1 got %0d exp 3", err_cnt_1); end
    do_clear();
    tick(); tick();
    evt_if.evt_ready = 1'b0;
  endtask

  task automatic test_multi();
    drive(1'b1, 4'h1, 4'h2, 4'h4, 4'h0);
    tick();
    sample = 1'b0;
    checks++; if (multi_fault !== 1'b1) begin errors++; $display("FAIL multi_set got %b exp 1", multi_fault); end
    checks++; if (err_cnt_1 !== 8'd1 || err_cnt_2 !== 8'd1 || err_cnt_3 !== 8'd1) begin errors++; $display("FAIL multi_cnts got %0d/%0d/%0d exp 1/1/1", err_cnt_1, err_cnt_2, err_cnt_3); end
`ifdef TMR_MON_EVENT_LOG_EN
    checks++; if (evt_if.evt_valid !== 1'b1 || evt_if.evt_data !== 8'hF0) begin errors++; $display("FAIL multi_evt got v=%b d=%h exp v=1 d=f0", evt_if.evt_valid, evt_if.evt_data); end
`endif
    evt_if.evt_ready = 1'b1;
    tick();
    evt_if.evt_ready = 1'b0;
    checks++; if (multi_fault !== 1'b0) begin errors++; $display("FAIL multi_pulse got %b exp 0", multi_fault); end
    drive(1'b1, 4'h1, 4'h1, 4'h4, 4'h1);
    tick();
    sample = 1'b0;
    checks++; if (multi_fault !== 1'b0) begin errors++; $display("FAIL multi_two_equal got %b exp 0", multi_fault); end
    checks++; if (err_cnt_3 !== 8'd2 || err_cnt_1 !== 8'd1) begin errors++; $display("FAIL multi_cnt_b got %0d/%0d exp 1/2", err_cnt_1, err_cnt_3); end
`ifdef TMR_MON_EVENT_LOG_EN
    checks++; if (evt_if.evt_valid !== 1'b1 || evt_if.evt_data !== 8'h81) begin errors++; $display("FAIL multi_evt_b got v=%b d=%h exp v=1 d=81", evt_if.evt_valid, evt_if.evt_data); end
`endif
    evt_if.evt_ready = 1'b1;
    tick();
    evt_if.evt_ready = 1'b0;
    do_clear();
  endtask

  task automatic test_overflow();
    logic [7:0] exp_q [4];
    exp_q[0] = 8'h22; exp_q[1] = 8'h23; exp_q[2] = 8'h24; exp_q[3] = 8'h29;
    evt_if.evt_ready = 1'b0;
    for (int v = 1; v <= 6; v++) begin
      drive(1'b1, 4'(v) ^ 4'h1, 4'(v), 4'(v), 4'(v));
      tick();
`ifdef TMR_MON_EVENT_LOG_EN
      if (v == 4) begin
        checks++; if (evt_if.evt_overflow !== 1'b0) begin errors++; $display("FAIL ovf_at_full got %b exp 0", evt_if.evt_overflow); end
      end
`endif
    end
    sample = 1'b0;
    checks++; if (err_cnt_1 !== 8'd6 || stuck !== 3'b001) begin errors++; $display("FAIL ovf_cnt got %0d stuck=%b exp 6/001", err_cnt_1, stuck); end
`ifdef TMR_MON_EVENT_LOG_EN
    checks++; if (evt_if.evt_overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got %b exp 1", evt_if.evt_overflow); end
    checks++; if (evt_if.evt_data !== 8'h21) begin errors++; $display("FAIL ovf_head got %h exp 21", evt_if.evt_data); end
    evt_if.evt_ready = 1'b1;
    drive(1'b1, 4'h8, 4'h9, 4'h9, 4'h9);
    tick();
    sample = 1'b0; evt_if.evt_ready = 1'b0;
    checks++; if (evt_if.evt_data !== 8'h22 || evt_if.evt_overflow !== 1'b1) begin errors++; $display("FAIL ovf_pushpop got d=%h o=%b exp 22/1", evt_if.evt_data, evt_if.evt_overflow); end
    do_clear();
    checks++; if (evt_if.evt_overflow !== 1'b0 || evt_if.evt_valid !== 1'b1 || evt_if.evt_data !== 8'h22) begin errors++; $display("FAIL ovf_clr got o=%b v=%b d=%h exp 0/1/22", evt_if.evt_overflow, evt_if.evt_valid, evt_if.evt_data); end
    evt_if.evt_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      checks++; if (evt_if.evt_valid !== 1'b1 || evt_if.evt_data !== exp_q[k]) begin errors++; $display("FAIL ovf_drain%0d got v=%b d=%h exp v=1 d=%h", k, evt_if.evt_valid, evt_if.evt_data, exp_q[k]); end
      tick();
    end
    evt_if.evt_ready = 1'b0;
    checks++; if (evt_if.evt_valid !== 1'b0) begin errors++; $display("FAIL ovf_empty got %b exp 0", evt_if.evt_valid); end
`else
    checks++; if (evt_if.evt_valid !== 1'b0 || evt_if.evt_overflow !== 1'b0 || evt_if.evt_data !== 8'h00) begin errors++; $display("FAIL ovf_no_log got v=%b o=%b d=%h exp 0/0/00", evt_if.evt_valid, evt_if.evt_overflow, evt_if.evt_data); end
    do_clear();
`endif
  endtask

  task automatic test_saturate();
    evt_if.evt_ready = 1'b1;
    drive(1'b1, 4'h5, 4'h5, 4'h6, 4'h5);
    repeat (255) tick();
    checks++; if (err_cnt_3 !== 8'd255 || stuck !== 3'b100) begin errors++; $display("FAIL sat_reach got %0d stuck=%b exp 255/100", err_cnt_3, stuck); end
    tick();
    sample = 1'b0;
    checks++; if (err_cnt_3 !== 8'd255) begin errors++; $display("FAIL sat_hold got %0d exp 255", err_cnt_3); end
    checks++; if (err_cnt_1 !== 8'd0 || err_cnt_2 !== 8'd0) begin errors++; $display("FAIL sat_others got %0d/%0d exp 0/0", err_cnt_1, err_cnt_2); end
    tick(); tick();
    checks++; if (evt_if.evt_overflow !== 1'b0 || evt_if.evt_valid !== 1'b0) begin errors++; $display("FAIL sat_stream got o=%b v=%b exp 0/0", evt_if.evt_overflow, evt_if.evt_valid); end
    evt_if.evt_ready = 1'b0;
    drive(1'b1, 4'h5, 4'h5, 4'h6, 4'h5);
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0; sample = 1'b0;
    checks++; if (err_cnt_3 !== 8'd0 || stuck !== 3'b000 || multi_fault !== 1'b0) begin errors++; $display("FAIL clr_coinc got cnt3=%0d stuck=%b mf=%b exp 0/000/0", err_cnt_3, stuck, multi_fault); end
    tick();
    checks++; if (evt_if.evt_valid !== 1'b0) begin errors++; $display("FAIL clr_coinc_evt got %b exp 0", evt_if.evt_valid); end
  endtask

  task automatic test_reset_mid();
    evt_if.evt_ready = 1'b0;
    drive(1'b1, 4'h2, 4'h1, 4'h1, 4'h1);
    repeat (6) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; sample = 1'b0;
    checks++; if (err_cnt_1 !== 8'd0 || stuck !== 3'b000) begin errors++; $display("FAIL rstmid_stats got cnt1=%0d stuck=%b exp 0/000", err_cnt_1, stuck); end
    checks++; if (evt_if.evt_valid !== 1'b0 || evt_if.evt_overflow !== 1'b0) begin errors++; $display("FAIL rstmid_evt got v=%b o=%b exp 0/0", evt_if.evt_valid, evt_if.evt_overflow); end
    tick();
    checks++; if (evt_if.evt_valid !== 1'b0) begin errors++; $display("FAIL rstmid_after got %b exp 0", evt_if.evt_valid); end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_persist();
    test_run_break();
    test_multi();
    test_overflow();
    test_saturate();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
